// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver with mid-bit sampling.
//
// The line is sampled once per bit at the bit centre. Timing comes from a
// 16-bit baud counter derived from CLK_FREQ / BAUD_RATE.
//
// Parameters:
//   CLK_FREQ   system clock frequency in Hz
//   BAUD_RATE  serial bit rate in bits/s
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rx         asynchronous serial input, idle high
//   data_out   last received byte, held between valid pulses
//   valid      one-cycle pulse when data_out is updated
//   busy       high while a frame is in progress (state != IDLE)
//   frame_err  one-cycle pulse on a low stop bit (only when checking is on)
//
// Build option:
//   UART_RX_FRAME_CHECK_EN  when defined, a low stop bit discards the byte
//                           and pulses frame_err. When undefined, the byte
//                           is still delivered and frame_err is tied low.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx #(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BAUD_RATE = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       busy,
   output logic       frame_err
);

   localparam int          BIT_PERIOD  = CLK_FREQ / BAUD_RATE;
   localparam int          HALF_PERIOD = BIT_PERIOD / 2;
   localparam logic [15:0] BIT_LAST    = 16'(BIT_PERIOD - 1);
   localparam logic [15:0] HALF_LAST   = 16'(HALF_PERIOD - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_sync1;
   logic        r_sync2;
   logic [15:0] r_cnt;
   logic [2:0]  r_bit_idx;
   logic [7:0]  r_shift;
   logic [7:0]  r_data_out;
   logic        r_valid;

   logic        w_rx_s;
   logic        w_half_tick;
   logic        w_bit_tick;
   logic        w_cnt_clr;
   logic        w_sample;
   logic        w_load;

   assign w_rx_s      = r_sync2;
   assign w_half_tick = (r_cnt == HALF_LAST);
   assign w_bit_tick  = (r_cnt == BIT_LAST);

   assign data_out = r_data_out;
   assign valid    = r_valid;
   assign busy     = (r_state != S_IDLE);

   // Two-flop synchronizer. It resets to the idle (high) level, so leaving
   // reset never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

`ifdef UART_RX_FRAME_CHECK_EN
   logic w_ferr;
   logic r_frame_err;

   assign frame_err = r_frame_err;
`else
   assign frame_err = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_clr   = 1'b0;
      w_sample    = 1'b0;
      w_load      = 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
      w_ferr      = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            w_cnt_clr = 1'b1;
            if (!w_rx_s) begin
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            // Re-check the start bit at its centre. A line that is already
            // high again was only a glitch.
            if (w_half_tick) begin
               w_cnt_clr = 1'b1;
               if (!w_rx_s) begin
                  w_state_nxt = S_DATA;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (w_bit_tick) begin
               w_cnt_clr = 1'b1;
               w_sample  = 1'b1;
               if (r_bit_idx == 3'd7) begin
                  w_state_nxt = S_STOP;
               end
            end
         end
         S_STOP: begin
            // Leaving at the stop-bit centre re-arms IDLE half a bit early.
            // This lets a start bit that follows immediately be caught.
            if (w_bit_tick) begin
               w_cnt_clr = 1'b1;
               if (w_rx_s) begin
                  w_load      = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
`ifdef UART_RX_FRAME_CHECK_EN
                  w_ferr      = 1'b1;
`else
                  w_load      = 1'b1;
`endif
                  w_state_nxt = S_WAIT_IDLE;
               end
            end
         end
         S_WAIT_IDLE: begin
            // A held-low line (break) is absorbed here instead of being
            // decoded as repeated 0x00 frames.
            w_cnt_clr = 1'b1;
            if (w_rx_s) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= 16'd0;
         r_bit_idx  <= 3'd0;
         r_shift    <= 8'h00;
         r_data_out <= 8'h00;
         r_valid    <= 1'b0;
      end else begin
         if (w_cnt_clr) begin
            r_cnt <= 16'd0;
         end else begin
            r_cnt <= r_cnt + 16'd1;
         end

         // The bit index is zero on every entry to DATA.
         if (r_state != S_DATA) begin
            r_bit_idx <= 3'd0;
         end else if (w_sample) begin
            r_shift[r_bit_idx] <= w_rx_s;
            r_bit_idx          <= r_bit_idx + 3'd1;
         end

         r_valid <= w_load;
         if (w_load) begin
            r_data_out <= r_shift;
         end
      end
   end

`ifdef UART_RX_FRAME_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= w_ferr;
      end
   end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed testbench for uart_rx.
// Bit period 16 clocks, half period 8.
// Covers: reset values, single frame with latency, back-to-back frames,
// start-bit glitch, bad stop bit followed by a break, and reset mid-frame.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx;

   localparam int CLK_FREQ  = 1_600_000;
   localparam int BAUD_RATE = 100_000;
   localparam int BP        = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx  = 1'b1;
   logic [7:0] data_out;
   logic       valid;
   logic       busy;
   logic       frame_err;

   uart_rx #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .data_out  (data_out),
      .valid     (valid),
      .busy      (busy),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   int checks  = 0;
   int errors  = 0;
   int cyc     = 0;
   int t0      = 0;
   int vcnt    = 0;
   int fcnt    = 0;
   int both    = 0;
   int chg_bad = 0;
   int vcyc    = 0;
   int vb      = 0;
   int fb      = 0;
   int lat     = 0;
   logic [7:0] vhist [0:31];
   logic [7:0] prev_dout = 8'h00;
   logic [7:0] b5a = 8'h5A;

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: counts pulses and logs each delivered byte.
   always @(negedge clk) begin
      if (rst) begin
         prev_dout = data_out;
      end else begin
         if (valid === 1'b1) begin
            vhist[vcnt[4:0]] = data_out;
            vcnt = vcnt + 1;
            vcyc = cyc;
         end else if (data_out !== prev_dout) begin
            chg_bad = chg_bad + 1;
         end
         if (frame_err === 1'b1) fcnt = fcnt + 1;
         if (valid === 1'b1 && frame_err === 1'b1) both = both + 1;
         prev_dout = data_out;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Call this 1ns after a rising edge. It drives start, 8 data bits
   // (LSB first) and the stop bit, each lasting BP clocks.
   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      t0 = cyc;
      for (int i = 0; i < 10; i++) begin
         rx = bits[i];
         repeat (BP) @(posedge clk);
         #1;
         if (i == 0) check("busy_in_frame", {31'd0, busy}, 32'd1);
      end
   endtask

   initial begin
      // reset values
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_data_out", {24'd0, data_out}, 32'h00);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;

      // single frame 0xA5
      vb = vcnt; fb = fcnt;
      send_frame(8'hA5, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      check("a5_valid_count", vcnt - vb, 32'd1);
      check("a5_byte", {24'd0, vhist[vb[4:0]]}, 32'hA5);
      check("a5_data_out", {24'd0, data_out}, 32'hA5);
      check("a5_busy_after", {31'd0, busy}, 32'd0);
      check("a5_ferr_count", fcnt - fb, 32'd0);
      lat = vcyc - t0;
      check("a5_latency_154_156", {31'd0, (lat >= 154 && lat <= 156)}, 32'd1);

      // back-to-back 0x00 then 0xFF
      vb = vcnt; fb = fcnt;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      check("b2b_valid_count", vcnt - vb, 32'd2);
      check("b2b_first", {24'd0, vhist[vb[4:0]]}, 32'h00);
      check("b2b_second", {24'd0, vhist[5'(vb + 1)]}, 32'hFF);
      check("b2b_data_out", {24'd0, data_out}, 32'hFF);
      check("b2b_ferr_count", fcnt - fb, 32'd0);

      // 4-cycle glitch on the idle line
      vb = vcnt; fb = fcnt;
      rx = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("glitch_busy_seen", {31'd0, busy}, 32'd1);
      rx = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("glitch_busy_after", {31'd0, busy}, 32'd0);
      check("glitch_valid_count", vcnt - vb, 32'd0);
      check("glitch_ferr_count", fcnt - fb, 32'd0);

      // 0x3C with a low stop bit, then the line held low for 40 bit times
      vb = vcnt; fb = fcnt;
      send_frame(8'h3C, 1'b0);
      repeat (40 * BP) @(posedge clk);
      #1;
      check("break_busy", {31'd0, busy}, 32'd1);
`ifdef UART_RX_FRAME_CHECK_EN
      check("break_ferr_count", fcnt - fb, 32'd1);
      check("break_valid_count", vcnt - vb, 32'd0);
      check("break_data_out", {24'd0, data_out}, 32'hFF);
`else
      check("break_ferr_count", fcnt - fb, 32'd0);
      check("break_valid_count", vcnt - vb, 32'd1);
      check("break_data_out", {24'd0, data_out}, 32'h3C);
`endif
      rx = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("break_busy_after", {31'd0, busy}, 32'd0);
`ifdef UART_RX_FRAME_CHECK_EN
      check("break_total_pulses", (vcnt - vb) + (fcnt - fb) * 16, 32'd16);
`else
      check("break_total_pulses", (vcnt - vb) + (fcnt - fb) * 16, 32'd1);
`endif

      // reset during data bit 4 of 0x5A, then 0x81
      vb = vcnt;
      rx = 1'b0;
      repeat (BP) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         rx = b5a[i];
         repeat (BP) @(posedge clk);
         #1;
      end
      rx = b5a[4];
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_data_out", {24'd0, data_out}, 32'h00);
      check("midrst_valid", {31'd0, valid}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
      repeat (8) @(posedge clk);
      #1;
      for (int i = 5; i < 8; i++) begin
         rx = b5a[i];
         repeat (BP) @(posedge clk);
         #1;
      end
      rx = 1'b1;
      repeat (2 * BP) @(posedge clk);
      #1;
      check("midrst_busy_held", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("midrst_no_valid", vcnt - vb, 32'd0);
      send_frame(8'h81, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      check("post_rst_valid_count", vcnt - vb, 32'd1);
      check("post_rst_byte", {24'd0, vhist[vb[4:0]]}, 32'h81);
      check("post_rst_data_out", {24'd0, data_out}, 32'h81);

      // global properties
      check("valid_ferr_overlap", both, 32'd0);
      check("data_out_change_without_valid", chg_bad, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
